pipe_fwd_chain: RTL and testbench
=================================

Name: pipe_fwd_chain

Overview:
Parametrised execute-to-writeback result pipeline that replaces the fixed E/M/W register chain and the hard-wired match compares.
- Carries DEPTH stages of {valid, we, late, dest tag, data}.
- Supports per-stage stall and flush, with automatic bubble insertion.
- Merges late (load) data at a configurable stage.
- Produces prioritised forwarding data and a load-use hazard for NSRC source operands.
- Sits between the ALU output and the register-file write port; the hazard controller consumes its hit and hazard outputs.

Parameters:
DATA_W, 32, payload width
TAG_W, 4, destination/source register tag width
DEPTH, 3, number of stages (index 0 = youngest, DEPTH-1 = writeback)
NSRC, 2, number of source operands checked for forwarding
LATE_STG, 2, stage index where late data is merged (1..DEPTH-1)
IGN_EN, 1, when 1, tag IGN_TAG never matches
IGN_TAG, 15, ignored tag (PC)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  entry presented to stage 0
in_we  in  1  entry writes the register file
in_late  in  1  data not final until LATE_STG (load)
in_tag  in  TAG_W  destination tag
in_data  in  DATA_W  ALU result
in_ready  out  1  stage 0 accepts this cycle (= ~hold[0])
late_data  in  DATA_W  memory read data for the entry about to enter LATE_STG
stall  in  DEPTH  per-stage stall request
flush  in  DEPTH  per-stage flush request
src_tag  in  NSRC*TAG_W  packed source tags
fwd_hit  out  NSRC  source s matches a valid, writing, non-late entry
fwd_stage  out  NSRC*$clog2(DEPTH)  index of the matching stage
fwd_data  out  NSRC*DATA_W  forwarded value (0 when no hit)
lu_hazard  out  1  some source's youngest match is late
out_valid, out_we  out  1  stage DEPTH-1 state
out_tag  out  TAG_W  stage DEPTH-1 tag
out_data  out  DATA_W  stage DEPTH-1 data

Behaviour:
- Reset (asynchronous, active-high): all valid/we/late bits and all tag/data registers = 0. Consequently out_valid=0, fwd_hit=0, lu_hazard=0, in_ready=1.
- Hold vector: hold[i] = OR of stall[j] for j>=i. A downstream stall freezes every upstream stage.
- Per stage i, each rising clk, in priority order:
  1. flush[i]: valid<=0 (tag/data hold, don't-care).
  2. hold[i]: all fields hold.
  3. i>0 and hold[i-1]: bubble, valid<=0.
  4. Otherwise stage i loads stage i-1. Stage 0 loads in_* gated by in_valid.
- Late merge: when stage LATE_STG loads a valid entry with late=1, data<=late_data and late<=0.
  - Entries at index >= LATE_STG never have late=1.
  - late_data is sampled only on that load edge.
- Matching: match(s,i) = valid[i] & we[i] & (tag[i]==src_tag[s]) & ~(IGN_EN & src_tag[s]==IGN_TAG). Combinational, evaluated on current register contents.
- Priority: the youngest (lowest-index) matching stage wins per source.
  - Winner not late: fwd_hit=1, fwd_stage=i, fwd_data=data[i].
  - Winner late: fwd_hit=0 and lu_hazard=1. An older matching stage is NOT used.
- Flushed or bubble stages never match.
- Forwarding outputs have zero latency relative to stage registers. Pipeline latency in_valid -> out_valid is DEPTH cycles with no stalls.
- Simultaneous flush and stall on the same stage: flush wins. The stage empties while upstream still holds.
- Reset mid-operation clears all in-flight entries immediately. No output glitch beyond the asynchronous clear.
- DEPTH=1 is legal: no bubble path, and LATE_STG is ignored (late entries never resolve; lu_hazard tracks them).

Decomposition:
- Shared package holds TAG_W and DATA_W defaults, the IGN_TAG constant for the PC, and a stage-index width helper constant.
- Natural sub-module: fwd_prio_sel. Per-source priority encoder over DEPTH match bits, returning hit, index and data. It is instantiated NSRC times.

Test Plan:
1. Reset, then in_valid=1, tag=3, data=0x11 for one cycle -> out_valid=1, out_tag=3, out_data=0x11 exactly 3 cycles later; out_valid=0 otherwise.
2. Back-to-back writes to tag 5 with data 0xA then 0xB, src_tag[0]=5 -> after the second edge, fwd_hit[0]=1, fwd_stage=0, fwd_data=0xB (youngest wins over stage 1).
3. Load with tag 2, in_late=1, data=0xDEAD, src_tag[1]=2 -> lu_hazard=1 and fwd_hit[1]=0 while in stages 0..1. With late_data=0x1234 on entry to stage 2: out_data=0x1234, fwd_data=0x1234, lu_hazard=0.
4. Stall[1]=1 for 2 cycles with entries A in stage 0 and B in stage 1 -> A and B hold, in_ready=0, stage 2 receives a bubble each cycle (out_valid=0). On release A and B advance in order.
5. flush[0]=1 and stall[0]=1 in the same cycle with a valid entry -> stage 0 valid=0 next cycle and no match on its tag.
6. src_tag=15 with a valid writing entry of tag 15 and IGN_EN=1 -> fwd_hit=0. With IGN_EN=0 -> fwd_hit=1.

Source files
------------

// File: rtl/pipe_fwd_chain_pkg.sv
// rtl/pipe_fwd_chain_pkg.sv - shared defaults and helpers for the result forwarding chain
package pipe_fwd_chain_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int PC_TAG     = 15;

    // Stage index width, never narrower than one bit so DEPTH=1 still has a port.
    function automatic int stg_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_fwd_chain_fwd_prio_sel.sv
// rtl/pipe_fwd_chain_fwd_prio_sel.sv - youngest-match priority select for one source operand
module fwd_prio_sel #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2
) (
    input  logic [DEPTH-1:0]        match_i,
    input  logic [DEPTH-1:0]        late_i,
    input  logic [DEPTH*DATA_W-1:0] data_i,
    output logic                    hit_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic [DATA_W-1:0]       data_o,
    output logic                    hazard_o
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end
    end

    // A late winner blocks forwarding entirely; older matches are stale.
    always_comb begin
        hit_o    = found & ~late_i[sel];
        hazard_o = found &  late_i[sel];
        idx_o    = hit_o ? sel : '0;
        data_o   = hit_o ? data_i[int'(sel) * DATA_W +: DATA_W] : '0;
    end

endmodule

// File: rtl/pipe_fwd_chain.sv
// rtl/pipe_fwd_chain.sv - parametrised execute-to-writeback result chain with forwarding
module pipe_fwd_chain
    import pipe_fwd_chain_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LATE_STG = 2,
    parameter int IGN_EN   = 1,
    parameter int IGN_TAG  = PC_TAG,
    parameter int IDX_W    = stg_idx_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_we,
    input  logic                   in_late,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      late_data,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    input  logic [NSRC*TAG_W-1:0]  src_tag,
    output logic [NSRC-1:0]        fwd_hit,
    output logic [NSRC*IDX_W-1:0]  fwd_stage,
    output logic [NSRC*DATA_W-1:0] fwd_data,
    output logic                   lu_hazard,
    output logic                   out_valid,
    output logic                   out_we,
    output logic [TAG_W-1:0]       out_tag,
    output logic [DATA_W-1:0]      out_data
);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  we_q, we_d;
    logic [DEPTH-1:0]  late_q, late_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  hold;
    logic [DEPTH*DATA_W-1:0] data_flat;
    logic [NSRC-1:0]   haz;

    always_comb begin
        hold[DEPTH-1] = stall[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    assign in_ready = ~hold[0];

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        late_d  = late_q;
        tag_d   = tag_q;
        data_d  = data_q;

        if (flush[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            we_d[0]    = in_valid & in_we;
            late_d[0]  = in_valid & in_late;
            tag_d[0]   = in_tag;
            data_d[0]  = in_data;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
            end else if (hold[i-1]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i-1];
                we_d[i]    = we_q[i-1];
                late_d[i]  = late_q[i-1];
                tag_d[i]   = tag_q[i-1];
                data_d[i]  = data_q[i-1];
                // Memory data lands exactly as the load enters the merge stage.
                if (i == LATE_STG && valid_q[i-1] && late_q[i-1]) begin
                    data_d[i] = late_data;
                    late_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            we_q    <= '0;
            late_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            late_q  <= late_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_flat[i*DATA_W +: DATA_W] = data_q[i];
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        logic [TAG_W-1:0] st;
        logic             ign;
        logic [DEPTH-1:0] m;

        assign st  = src_tag[s*TAG_W +: TAG_W];
        assign ign = (IGN_EN != 0) && (st == TAG_W'(IGN_TAG));

        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                m[i] = valid_q[i] & we_q[i] & (tag_q[i] == st) & ~ign;
            end
        end

        fwd_prio_sel #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_sel (
            .match_i  (m),
            .late_i   (late_q),
            .data_i   (data_flat),
            .hit_o    (fwd_hit[s]),
            .idx_o    (fwd_stage[s*IDX_W +: IDX_W]),
            .data_o   (fwd_data[s*DATA_W +: DATA_W]),
            .hazard_o (haz[s])
        );
    end

    assign lu_hazard = |haz;
    assign out_valid = valid_q[DEPTH-1];
    assign out_we    = we_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_fwd_chain.sv
// tb/tb_pipe_fwd_chain.sv - scoreboard bench for pipe_fwd_chain
module tb_pipe_fwd_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_we, in_late;
    logic [3:0]  in_tag;
    logic [31:0] in_data, late_data;
    logic [2:0]  stall, flush;
    logic [7:0]  src_tag;

    logic        in_ready, lu_hazard, out_valid, out_we;
    logic [1:0]  fwd_hit;
    logic [3:0]  fwd_stage;
    logic [63:0] fwd_data;
    logic [3:0]  out_tag;
    logic [31:0] out_data;

    logic        a_in_ready, a_lu_hazard, a_out_valid, a_out_we;
    logic [1:0]  a_fwd_hit;
    logic [3:0]  a_fwd_stage;
    logic [63:0] a_fwd_data;
    logic [3:0]  a_out_tag;
    logic [31:0] a_out_data;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        we;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   applied = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_fwd_chain dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_late(in_late),
        .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready), .late_data(late_data),
        .stall(stall), .flush(flush), .src_tag(src_tag), .fwd_hit(fwd_hit),
        .fwd_stage(fwd_stage), .fwd_data(fwd_data), .lu_hazard(lu_hazard),
        .out_valid(out_valid), .out_we(out_we), .out_tag(out_tag), .out_data(out_data)
    );

    pipe_fwd_chain #(.IGN_EN(0)) dut_noign (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_late(in_late),
        .in_tag(in_tag), .in_data(in_data), .in_ready(a_in_ready), .late_data(late_data),
        .stall(stall), .flush(flush), .src_tag(src_tag), .fwd_hit(a_fwd_hit),
        .fwd_stage(a_fwd_stage), .fwd_data(a_fwd_data), .lu_hazard(a_lu_hazard),
        .out_valid(a_out_valid), .out_we(a_out_we), .out_tag(a_out_tag), .out_data(a_out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] t, input logic [31:0] d, input logic late, input logic we);
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = d;
        in_late  = late;
        in_we    = we;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_late  = 1'b0;
        in_we    = 1'b0;
    endtask

    task automatic push(input logic [3:0] t, input logic [31:0] d, input logic we, input int due);
        exp_t x;
        x.tag = t; x.data = d; x.we = we; x.due = due;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sbq.size() == 0) begin
                chk("out_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("out_tag", 32'(out_tag), 32'(e.tag));
                chk("out_data", out_data, e.data);
                chk("out_we", 32'(out_we), 32'(e.we));
                if (e.due != 0) chk("out_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        in_tag = '0; in_data = '0;
        stall = '0; flush = '0; src_tag = '0;
        late_data = 32'hBAD;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fwd_hit", 32'(fwd_hit), 0);
        chk("rst_lu_hazard", 32'(lu_hazard), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        reset = 1'b0;
        step();

        // single entry latency
        drive(4'd3, 32'h11, 1'b0, 1'b1);
        push(4'd3, 32'h11, 1'b1, cyc + 3);
        step();
        idle();
        src_tag = {4'd0, 4'd3};
        #1;
        chk("t1_hit", 32'(fwd_hit[0]), 1);
        chk("t1_stage", 32'(fwd_stage[1:0]), 0);
        chk("t1_data", fwd_data[31:0], 32'h11);
        repeat (3) step();
        chk("t1_after_out", 32'(out_valid), 0);

        // youngest of two writers wins
        drive(4'd5, 32'hA, 1'b0, 1'b1);
        push(4'd5, 32'hA, 1'b1, cyc + 3);
        step();
        drive(4'd5, 32'hB, 1'b0, 1'b1);
        push(4'd5, 32'hB, 1'b1, cyc + 3);
        step();
        idle();
        src_tag = {4'd0, 4'd5};
        #1;
        chk("t2_hit", 32'(fwd_hit[0]), 1);
        chk("t2_stage", 32'(fwd_stage[1:0]), 0);
        chk("t2_data", fwd_data[31:0], 32'hB);
        step();
        #1;
        chk("t2_stage_adv", 32'(fwd_stage[1:0]), 1);
        chk("t2_data_adv", fwd_data[31:0], 32'hB);
        repeat (2) step();

        // load-use: older non-late match must not be forwarded
        drive(4'd2, 32'h77, 1'b0, 1'b1);
        push(4'd2, 32'h77, 1'b1, cyc + 3);
        step();
        drive(4'd2, 32'hDEAD, 1'b1, 1'b1);
        push(4'd2, 32'h1234, 1'b1, cyc + 3);
        src_tag = {4'd2, 4'd0};
        step();
        idle();
        #1;
        chk("t3_haz_s0", 32'(lu_hazard), 1);
        chk("t3_hit_s0", 32'(fwd_hit[1]), 0);
        step();
        late_data = 32'h1234;
        #1;
        chk("t3_haz_s1", 32'(lu_hazard), 1);
        chk("t3_hit_s1", 32'(fwd_hit[1]), 0);
        step();
        late_data = 32'hBAD;
        #1;
        chk("t3_hit_s2", 32'(fwd_hit[1]), 1);
        chk("t3_stage_s2", 32'(fwd_stage[3:2]), 2);
        chk("t3_data_s2", fwd_data[63:32], 32'h1234);
        chk("t3_haz_s2", 32'(lu_hazard), 0);
        step();

        // stall stage 1: upstream holds, bubbles go downstream
        src_tag = '0;
        drive(4'd7, 32'h71, 1'b0, 1'b1);
        push(4'd7, 32'h71, 1'b1, 0);
        step();
        drive(4'd6, 32'h61, 1'b0, 1'b1);
        push(4'd6, 32'h61, 1'b1, 0);
        step();
        idle();
        stall = 3'b010;
        src_tag = {4'd6, 4'd7};
        #1;
        chk("t4_ready", 32'(in_ready), 0);
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            chk("t4_bubble", 32'(out_valid), 0);
            chk("t4_ready_hold", 32'(in_ready), 0);
            chk("t4_b_stage", 32'(fwd_stage[1:0]), 1);
            chk("t4_a_stage", 32'(fwd_stage[3:2]), 0);
        end
        stall = 3'b000;
        repeat (3) step();

        // flush beats stall on stage 0
        src_tag = '0;
        drive(4'd8, 32'h81, 1'b0, 1'b1);
        step();
        idle();
        stall = 3'b001;
        flush = 3'b001;
        step();
        stall = 3'b000;
        flush = 3'b000;
        src_tag = {4'd0, 4'd8};
        #1;
        chk("t5_flush_hit", 32'(fwd_hit[0]), 0);
        chk("t5_flush_haz", 32'(lu_hazard), 0);
        repeat (3) step();

        // ignored PC tag and non-writing entries
        drive(4'd15, 32'hF5, 1'b0, 1'b1);
        push(4'd15, 32'hF5, 1'b1, cyc + 3);
        step();
        drive(4'd9, 32'h99, 1'b0, 1'b0);
        push(4'd9, 32'h99, 1'b0, cyc + 3);
        src_tag = {4'd9, 4'd15};
        #1;
        chk("t6_ign_hit", 32'(fwd_hit[0]), 0);
        chk("t6_noign_hit", 32'(a_fwd_hit[0]), 1);
        chk("t6_noign_data", a_fwd_data[31:0], 32'hF5);
        step();
        idle();
        #1;
        chk("t6_nowe_hit", 32'(fwd_hit[1]), 0);
        repeat (3) step();

        // asynchronous reset clears in-flight entries
        drive(4'd4, 32'h44, 1'b0, 1'b1);
        step();
        idle();
        src_tag = {4'd0, 4'd4};
        #1;
        chk("t7_pre_hit", 32'(fwd_hit[0]), 1);
        reset = 1'b1;
        #1;
        chk("t7_rst_hit", 32'(fwd_hit[0]), 0);
        chk("t7_rst_ready", 32'(in_ready), 1);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("t7_rst_out", 32'(out_valid), 0);

        for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
